// File: rtl/wfifo_arb_pkg.sv
// Shared types and helpers for the write-FIFO port arbiter.
// Latency: none (types, constants and a combinational function).
// Backpressure: n/a.
package wfifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int CNT_W   = 8;
  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid[0 +: n], searching from ptr upward with wrap.
  // The scan runs from the far end down, so the offset nearest ptr wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int                 n);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (valid[idx]) begin
          r.found = 1'b1;
          r.idx   = 3'(idx);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wfifo_wr_arbiter_rr_arbiter_core.sv
// Rotating-priority encoder: picks the first valid requester at or after ptr.
// Latency: purely combinational. Backpressure: none, the caller qualifies use.
// Ports: valid (request vector), ptr (search start), idx (winner), found (any valid).
module rr_arbiter_core
  import wfifo_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             found
);

  logic [MAX_REQ-1:0] valid_pad;
  rr_pick_t           pick;

  always_comb begin
    valid_pad              = '0;
    valid_pad[N_REQ-1:0]   = valid;
    pick                   = rr_pick(valid_pad, 3'(ptr), N_REQ);
  end

  assign idx   = IW'(pick.idx);
  assign found = pick.found;

endmodule

// File: rtl/wfifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the single write port of the write-side async FIFO.
// Latency: grant 1 cycle after request from IDLE; beats pass to the FIFO with zero added latency.
// Backpressure: fifo_full drops the owner's req_ready in the same cycle, so no beat is ever dropped.
// Ports: req_valid/req_last/req_data/req_ready per requester; fifo_full/fifo_wdata_vld/fifo_wdata
//        to the FIFO; owner_vld/owner_id grant status; err_timeout/err_id idle-timeout report.
module wfifo_wr_arbiter
  import wfifo_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DW        = 32,
  parameter  int MAX_BURST = 8,
  parameter  int TIMEOUT   = 16,
  localparam int IW        = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_last,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                fifo_full,
  output logic                fifo_wdata_vld,
  output logic [DW-1:0]       fifo_wdata,
  output logic                owner_vld,
  output logic [IW-1:0]       owner_id,
  output logic                err_timeout,
  output logic [IW-1:0]       err_id
);

  arb_state_e       state, state_nxt;
  logic [IW-1:0]    owner_nxt, rr_ptr, rr_ptr_nxt, err_id_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_nxt, idle_cnt, idle_nxt;
  logic             err_to_nxt;

  logic             burst, own_valid, own_last, accept;
  logic             rel_last, rel_cap, rel_idle, rel_any;
  logic [IW-1:0]    nxt_ptr, arb_ptr, pick_idx;
  logic [N_REQ-1:0] arb_valid;
  logic             pick_found;

  // Datapath and release detection.
  always_comb begin
    burst     = (state == BURST);
    own_valid = req_valid[owner_id];
    own_last  = req_last[owner_id];
    accept    = burst & own_valid & ~fifo_full;

    req_ready = '0;
    if (burst && !fifo_full) req_ready[owner_id] = 1'b1;

    fifo_wdata_vld = accept;
    fifo_wdata     = burst ? req_data[int'(owner_id)*DW +: DW] : '0;
    owner_vld      = burst;

    rel_last = accept & own_last;
    rel_cap  = accept & (beat_cnt == CNT_W'(MAX_BURST - 1));
    rel_idle = burst & ~own_valid & (idle_cnt == CNT_W'(TIMEOUT - 1));
    rel_any  = rel_last | rel_cap | rel_idle;

    nxt_ptr = (owner_id == IW'(N_REQ - 1)) ? '0 : owner_id + IW'(1);
    arb_ptr = burst ? nxt_ptr : rr_ptr;

    // A releaser that just sent its last beat has nothing further to offer, even
    // though its valid is still high for that beat; a capped owner does compete.
    arb_valid = req_valid;
    if (rel_last) arb_valid[owner_id] = 1'b0;
  end

  rr_arbiter_core #(.N_REQ(N_REQ)) u_rr (
    .valid (arb_valid),
    .ptr   (arb_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state, grant and counters.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner_id;
    rr_ptr_nxt = rr_ptr;
    beat_nxt   = beat_cnt;
    idle_nxt   = idle_cnt;
    err_to_nxt = 1'b0;
    err_id_nxt = err_id;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = BURST;
          owner_nxt = pick_idx;
          beat_nxt  = '0;
          idle_nxt  = '0;
        end
      end
      BURST: begin
        if (rel_any) begin
          rr_ptr_nxt = nxt_ptr;
          beat_nxt   = '0;
          idle_nxt   = '0;
          if (rel_idle) begin
            err_to_nxt = 1'b1;
            err_id_nxt = owner_id;
          end
          if (pick_found) owner_nxt = pick_idx;
          else            state_nxt = IDLE;
        end else begin
          if (accept && beat_cnt != '1) beat_nxt = beat_cnt + CNT_W'(1);
          // A full-stalled owner with data pending is not idle.
          if (own_valid)             idle_nxt = '0;
          else if (idle_cnt != '1)   idle_nxt = idle_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner_id    <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      idle_cnt    <= '0;
      err_timeout <= 1'b0;
      err_id      <= '0;
    end else begin
      state       <= state_nxt;
      owner_id    <= owner_nxt;
      rr_ptr      <= rr_ptr_nxt;
      beat_cnt    <= beat_nxt;
      idle_cnt    <= idle_nxt;
      err_timeout <= err_to_nxt;
      err_id      <= err_id_nxt;
    end
  end

endmodule

// File: tb/tb_wfifo_wr_arbiter.sv
// Directed bench for wfifo_wr_arbiter: requester packet sources plus hand-computed expectations.
// Inputs change at the falling edge; outputs are sampled 1 time unit after that.
module tb_wfifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            fifo_full, fifo_wdata_vld;
  logic [DW-1:0]   fifo_wdata;
  logic            owner_vld;
  logic [1:0]      owner_id;
  logic            err_timeout;
  logic [1:0]      err_id;

  wfifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(8), .TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .fifo_full      (fifo_full),
    .fifo_wdata_vld (fifo_wdata_vld),
    .fifo_wdata     (fifo_wdata),
    .owner_vld      (owner_vld),
    .owner_id       (owner_id),
    .err_timeout    (err_timeout),
    .err_id         (err_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Requester sources: rem beats left in the current packet, npk packets queued after it.
  int            rem [N];
  int            npk [N];
  int            plen[N];
  logic [DW-1:0] dat [N];
  logic          en  [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = en[i] && (rem[i] > 0);
      req_last[i]           = (rem[i] == 1);
      req_data[i*DW +: DW]  = dat[i];
    end
  endtask

  task automatic setq(input int i, input int r, input logic [DW-1:0] base);
    rem[i]  = r;
    plen[i] = r;
    npk[i]  = 0;
    dat[i]  = base;
    en[i]   = 1'b1;
  endtask

  // Advance one cycle: handshakes visible now complete at the coming rising edge.
  task automatic cyc();
    logic [N-1:0] acc;
    acc = req_valid & req_ready;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        dat[i] = dat[i] + 1;
        rem[i]--;
        if (rem[i] == 0 && npk[i] > 0) begin
          rem[i] = plen[i];
          npk[i]--;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic wr(input string tag, input int own, input logic [DW-1:0] d);
    check({tag, ".vld"}, 64'(fifo_wdata_vld), 64'd1);
    check({tag, ".own"}, 64'(owner_id), 64'(own));
    check({tag, ".dat"}, 64'(fifo_wdata), 64'(d));
  endtask

  int            rr_own[8] = '{0, 0, 1, 1, 2, 2, 0, 0};
  logic [DW-1:0] rr_dat[8] = '{32'h00, 32'h01, 32'h10, 32'h11, 32'h20, 32'h21, 32'h02, 32'h03};

  initial begin
    rst       = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; npk[i] = 0; plen[i] = 0; dat[i] = '0; en[i] = 1'b0;
    end
    drive();
    repeat (2) @(negedge clk);
    #1;

    // Reset state
    check("rst.owner_vld", 64'(owner_vld), 64'd0);
    check("rst.owner_id", 64'(owner_id), 64'd0);
    check("rst.wvld", 64'(fifo_wdata_vld), 64'd0);
    check("rst.wdata", 64'(fifo_wdata), 64'd0);
    check("rst.ready", 64'(req_ready), 64'd0);
    check("rst.err_to", 64'(err_timeout), 64'd0);
    check("rst.err_id", 64'(err_id), 64'd0);
    rst = 1'b0;

    // Single requester, 3-beat packet
    setq(1, 3, 32'hA0);
    drive();
    #1;
    check("t1.idle_ready", 64'(req_ready), 64'd0);
    check("t1.idle_owner_vld", 64'(owner_vld), 64'd0);
    cyc();
    check("t1.grant_vld", 64'(owner_vld), 64'd1);
    check("t1.ready", 64'(req_ready), 64'b0010);
    wr("t1.b0", 1, 32'hA0);
    cyc(); wr("t1.b1", 1, 32'hA1);
    cyc(); wr("t1.b2", 1, 32'hA2);
    cyc();
    check("t1.released", 64'(owner_vld), 64'd0);
    check("t1.no_write", 64'(fifo_wdata_vld), 64'd0);
    // Pointer now at 2: with 0 and 3 pending, 3 wins, then 0 with no bubble.
    setq(0, 1, 32'hC0);
    setq(3, 1, 32'hC3);
    drive();
    #1;
    cyc(); wr("t1.ptr3", 3, 32'hC3);
    cyc(); wr("t1.ptr0", 0, 32'hC0);
    cyc();
    check("t1.ptr_idle", 64'(owner_vld), 64'd0);

    // Round-robin from reset: 0,1,2,0 with 2-beat packets
    rst = 1'b1;
    #1;
    rst = 1'b0;
    setq(0, 2, 32'h00);
    npk[0] = 1;
    setq(1, 2, 32'h10);
    setq(2, 2, 32'h20);
    drive();
    #1;
    cyc();
    for (int k = 0; k < 8; k++) begin
      wr($sformatf("t2.w%0d", k), rr_own[k], rr_dat[k]);
      cyc();
    end
    check("t2.idle", 64'(owner_vld), 64'd0);

    // MAX_BURST cap: 3 streams 20 beats, 0 has one 2-beat packet
    setq(3, 20, 32'h30);
    setq(0, 2, 32'h40);
    drive();
    #1;
    cyc();
    for (int k = 0; k < 8; k++) begin
      wr($sformatf("t3.a%0d", k), 3, 32'h30 + k);
      cyc();
    end
    wr("t3.o0", 0, 32'h40); cyc();
    wr("t3.o1", 0, 32'h41); cyc();
    for (int k = 0; k < 8; k++) begin
      wr($sformatf("t3.b%0d", k), 3, 32'h38 + k);
      cyc();
    end
    for (int k = 0; k < 4; k++) begin
      wr($sformatf("t3.c%0d", k), 3, 32'h40 + k);
      cyc();
    end
    check("t3.idle", 64'(owner_vld), 64'd0);

    // Backpressure: 5 full cycles mid-burst, no beat counted, no timeout
    setq(1, 10, 32'h50);
    setq(2, 1, 32'h60);
    drive();
    #1;
    cyc();
    wr("t4.b0", 1, 32'h50); cyc();
    wr("t4.b1", 1, 32'h51); cyc();
    fifo_full = 1'b1;
    #1;
    for (int s = 0; s < 5; s++) begin
      check($sformatf("t4.s%0d.ready", s), 64'(req_ready), 64'd0);
      check($sformatf("t4.s%0d.wvld", s), 64'(fifo_wdata_vld), 64'd0);
      check($sformatf("t4.s%0d.own", s), 64'(owner_id), 64'd1);
      check($sformatf("t4.s%0d.err", s), 64'(err_timeout), 64'd0);
      cyc();
    end
    fifo_full = 1'b0;
    #1;
    for (int k = 2; k < 8; k++) begin
      wr($sformatf("t4.b%0d", k), 1, 32'h50 + k);
      cyc();
    end
    wr("t4.r2", 2, 32'h60); cyc();
    wr("t4.r1a", 1, 32'h58); cyc();
    wr("t4.r1b", 1, 32'h59); cyc();
    check("t4.idle", 64'(owner_vld), 64'd0);

    // Idle timeout: owner 2 stalls after one beat, 0 is waiting
    setq(2, 3, 32'h70);
    setq(0, 1, 32'h80);
    drive();
    #1;
    cyc();
    wr("t5.b0", 2, 32'h70);
    en[2] = 1'b0;
    cyc();
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("t5.i%0d.own", k), 64'(owner_id), 64'd2);
      check($sformatf("t5.i%0d.err", k), 64'(err_timeout), 64'd0);
      check($sformatf("t5.i%0d.wvld", k), 64'(fifo_wdata_vld), 64'd0);
      cyc();
    end
    check("t5.err_pulse", 64'(err_timeout), 64'd1);
    check("t5.err_id", 64'(err_id), 64'd2);
    wr("t5.next", 0, 32'h80);
    cyc();
    check("t5.err_drop", 64'(err_timeout), 64'd0);
    check("t5.err_id_hold", 64'(err_id), 64'd2);
    check("t5.idle", 64'(owner_vld), 64'd0);

    // Async reset mid-burst, then arbitration from pointer 0
    setq(3, 4, 32'h90);
    drive();
    #1;
    cyc();
    wr("t6.b0", 3, 32'h90); cyc();
    wr("t6.b1", 3, 32'h91);
    rst = 1'b1;
    #1;
    check("t6.owner_vld", 64'(owner_vld), 64'd0);
    check("t6.wvld", 64'(fifo_wdata_vld), 64'd0);
    check("t6.ready", 64'(req_ready), 64'd0);
    check("t6.wdata", 64'(fifo_wdata), 64'd0);
    check("t6.owner_id", 64'(owner_id), 64'd0);
    rst = 1'b0;
    setq(0, 1, 32'hB0);
    drive();
    #1;
    cyc();
    wr("t6.r0", 0, 32'hB0); cyc();
    wr("t6.r1", 3, 32'h91); cyc();
    wr("t6.r2", 3, 32'h92); cyc();
    wr("t6.r3", 3, 32'h93); cyc();
    check("t6.idle", 64'(owner_vld), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
